ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the Z80 and a supervisor: CPU normally wins,
// supervisor gets a slot once it has waited SUP_MAX_WAIT cycles.
module ram_port_arbiter #(
  parameter int SUP_MAX_WAIT = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] cpu_a_i,
  input  logic [7:0]  cpu_d_i,
  input  logic        cpu_nmreq_i,
  input  logic        cpu_nrd_i,
  input  logic        cpu_nwr_i,
  output logic [7:0]  cpu_d_o,
  output logic        cpu_nwait_o,
  input  logic        sup_req_i,
  input  logic        sup_we_i,
  input  logic [15:0] sup_a_i,
  input  logic [7:0]  sup_d_i,
  output logic        sup_ack_o,
  output logic [7:0]  sup_d_o,
  output logic [15:0] ram_a_o,
  output logic [7:0]  ram_d_o,
  output logic        ram_we_o,
  input  logic [7:0]  ram_q_i
);

  localparam int CW = (SUP_MAX_WAIT < 1) ? 1 : $clog2(SUP_MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_LAT, SUP_ACC, SUP_LAT, SUP_DONE} state_t;

  state_t        state_q, state_d;
  logic          served_q, served_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          acc_wr_q, acc_wr_d;
  logic          cpu_turn_q, cpu_turn_d;
  logic [15:0]   ram_a_q, ram_a_d;
  logic [7:0]    ram_d_q, ram_d_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    cpu_d_q, cpu_d_d;
  logic [7:0]    sup_d_q, sup_d_d;
  logic          sup_ack_q, sup_ack_d;

  logic cpu_req, in_sup, starve_full, sup_win;

  assign cpu_req     = !cpu_nmreq_i && (!cpu_nrd_i || !cpu_nwr_i) && !served_q;
  assign in_sup      = state_q inside {SUP_ACC, SUP_LAT, SUP_DONE};
  assign starve_full = (starve_q == CW'(SUP_MAX_WAIT));
  // cpu_turn_q guarantees the CPU one slot after every supervisor access,
  // even when the starve limit is zero.
  assign sup_win     = sup_req_i && (!cpu_req || (starve_full && !cpu_turn_q));

  always_comb begin
    state_d    = state_q;
    served_d   = served_q;
    starve_d   = starve_q;
    acc_wr_d   = acc_wr_q;
    cpu_turn_d = cpu_turn_q;
    ram_a_d    = ram_a_q;
    ram_d_d    = ram_d_q;
    ram_we_d   = 1'b0;
    cpu_d_d    = cpu_d_q;
    sup_d_d    = sup_d_q;
    sup_ack_d  = 1'b0;

    if (sup_req_i && !in_sup && !starve_full)
      starve_d = starve_q + CW'(1);

    if ((state_q == CPU_ACC && acc_wr_q) || state_q == CPU_LAT)
      served_d = 1'b1;
    // Strobe release wins so a cycle ending mid-access still rearms the CPU.
    if (cpu_nmreq_i)
      served_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sup_win) begin
          state_d    = SUP_ACC;
          ram_a_d    = sup_a_i;
          ram_d_d    = sup_d_i;
          ram_we_d   = sup_we_i;
          acc_wr_d   = sup_we_i;
          starve_d   = '0;
          cpu_turn_d = 1'b0;
        end else if (cpu_req) begin
          state_d    = CPU_ACC;
          ram_a_d    = cpu_a_i;
          ram_d_d    = cpu_d_i;
          ram_we_d   = !cpu_nwr_i;
          acc_wr_d   = !cpu_nwr_i;
          cpu_turn_d = 1'b0;
        end
      end
      CPU_ACC: state_d = acc_wr_q ? IDLE : CPU_LAT;
      CPU_LAT: begin
        cpu_d_d = ram_q_i;
        state_d = IDLE;
      end
      SUP_ACC: state_d = SUP_LAT;
      SUP_LAT: begin
        if (!acc_wr_q) sup_d_d = ram_q_i;
        sup_ack_d = 1'b1;
        state_d   = SUP_DONE;
      end
      SUP_DONE: begin
        cpu_turn_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      served_q   <= 1'b0;
      starve_q   <= '0;
      acc_wr_q   <= 1'b0;
      cpu_turn_q <= 1'b0;
      ram_a_q    <= '0;
      ram_d_q    <= '0;
      ram_we_q   <= 1'b0;
      cpu_d_q    <= 8'hFF;
      sup_d_q    <= '0;
      sup_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      served_q   <= served_d;
      starve_q   <= starve_d;
      acc_wr_q   <= acc_wr_d;
      cpu_turn_q <= cpu_turn_d;
      ram_a_q    <= ram_a_d;
      ram_d_q    <= ram_d_d;
      ram_we_q   <= ram_we_d;
      cpu_d_q    <= cpu_d_d;
      sup_d_q    <= sup_d_d;
      sup_ack_q  <= sup_ack_d;
    end
  end

  assign ram_a_o     = ram_a_q;
  assign ram_d_o     = ram_d_q;
  assign ram_we_o    = ram_we_q;
  assign cpu_d_o     = cpu_d_q;
  assign sup_d_o     = sup_d_q;
  assign sup_ack_o   = sup_ack_q;
  assign cpu_nwait_o = !(cpu_req && in_sup);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural two-edge-latency RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_nmreq, cpu_nrd, cpu_nwr;
  logic [7:0]  cpu_q;
  logic        cpu_nwait;
  logic        sup_req, sup_we;
  logic [15:0] sup_a;
  logic [7:0]  sup_d;
  logic        sup_ack;
  logic [7:0]  sup_q;
  logic [15:0] ram_a;
  logic [7:0]  ram_d;
  logic        ram_we;
  logic [7:0]  ram_q;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:65535];

  ram_port_arbiter #(.SUP_MAX_WAIT(8)) dut (
    .clk_i(clk), .reset_i(rst),
    .cpu_a_i(cpu_a), .cpu_d_i(cpu_d),
    .cpu_nmreq_i(cpu_nmreq), .cpu_nrd_i(cpu_nrd), .cpu_nwr_i(cpu_nwr),
    .cpu_d_o(cpu_q), .cpu_nwait_o(cpu_nwait),
    .sup_req_i(sup_req), .sup_we_i(sup_we), .sup_a_i(sup_a), .sup_d_i(sup_d),
    .sup_ack_o(sup_ack), .sup_d_o(sup_q),
    .ram_a_o(ram_a), .ram_d_o(ram_d), .ram_we_o(ram_we), .ram_q_i(ram_q)
  );

  always #5 clk = ~clk;

  // Address registered on one edge, data presented for the following edge.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_nmreq = 1'b1; cpu_nrd = 1'b1; cpu_nwr = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_a = a; cpu_d = d; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
    tick();
    cpu_idle();
    tick();
  endtask

  task automatic test_reset();
    #1;
    total++; if (ram_we !== 1'b0 || ram_a !== 16'h0 || ram_d !== 8'h0) begin bad++;
      $display("FAIL reset_ram: we=%b a=%h d=%h want 0/0000/00", ram_we, ram_a, ram_d); end
    total++; if (cpu_q !== 8'hFF || cpu_nwait !== 1'b1) begin bad++;
      $display("FAIL reset_cpu: d=%h nwait=%b want ff/1", cpu_q, cpu_nwait); end
    total++; if (sup_ack !== 1'b0 || sup_q !== 8'h00) begin bad++;
      $display("FAIL reset_sup: ack=%b d=%h want 0/00", sup_ack, sup_q); end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write_read();
    cpu_a = 16'h4000; cpu_d = 8'h5A; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
    tick();
    total++; if (ram_we !== 1'b1 || ram_a !== 16'h4000 || ram_d !== 8'h5A) begin bad++;
      $display("FAIL cpu_wr_grant: we=%b a=%h d=%h want 1/4000/5a", ram_we, ram_a, ram_d); end
    cpu_idle();
    tick();
    total++; if (ram_we !== 1'b0) begin bad++;
      $display("FAIL cpu_wr_pulse: we=%b want 0", ram_we); end
    cpu_nmreq = 1'b0; cpu_nrd = 1'b0;
    tick();
    total++; if (ram_we !== 1'b0 || ram_a !== 16'h4000 || cpu_nwait !== 1'b1) begin bad++;
      $display("FAIL cpu_rd_grant: we=%b a=%h nwait=%b want 0/4000/1", ram_we, ram_a, cpu_nwait); end
    tick();
    total++; if (cpu_q !== 8'hFF) begin bad++;
      $display("FAIL cpu_rd_early: d=%h want ff", cpu_q); end
    tick();
    total++; if (cpu_q !== 8'h5A || cpu_nwait !== 1'b1) begin bad++;
      $display("FAIL cpu_rd_data: d=%h nwait=%b want 5a/1", cpu_q, cpu_nwait); end
    cpu_idle();
    tick();
  endtask

  task automatic test_sup_write_read();
    sup_req = 1'b1; sup_we = 1'b1; sup_a = 16'hC000; sup_d = 8'hA5;
    tick();
    total++; if (ram_we !== 1'b1 || ram_a !== 16'hC000 || ram_d !== 8'hA5 || sup_ack !== 1'b0) begin bad++;
      $display("FAIL sup_wr_grant: we=%b a=%h d=%h ack=%b want 1/c000/a5/0", ram_we, ram_a, ram_d, sup_ack); end
    tick();
    total++; if (sup_ack !== 1'b0 || ram_we !== 1'b0) begin bad++;
      $display("FAIL sup_wr_lat: ack=%b we=%b want 0/0", sup_ack, ram_we); end
    tick();
    total++; if (sup_ack !== 1'b1) begin bad++;
      $display("FAIL sup_wr_ack: ack=%b want 1", sup_ack); end
    sup_req = 1'b0;
    tick();
    total++; if (sup_ack !== 1'b0 || sup_q !== 8'h00) begin bad++;
      $display("FAIL sup_wr_done: ack=%b d=%h want 0/00", sup_ack, sup_q); end
    sup_req = 1'b1; sup_we = 1'b0;
    tick();
    tick();
    tick();
    total++; if (sup_ack !== 1'b1 || sup_q !== 8'hA5) begin bad++;
      $display("FAIL sup_rd_ack: ack=%b d=%h want 1/a5", sup_ack, sup_q); end
    sup_req = 1'b0;
    tick();
    total++; if (sup_ack !== 1'b0) begin bad++;
      $display("FAIL sup_rd_pulse: ack=%b want 0", sup_ack); end
  endtask

  task automatic test_cpu_during_sup();
    cpu_write(16'h4001, 8'hC3);
    sup_req = 1'b1; sup_we = 1'b0; sup_a = 16'hC000;
    tick();
    cpu_a = 16'h4001; cpu_nmreq = 1'b0; cpu_nrd = 1'b0;
    #1;
    total++; if (cpu_nwait !== 1'b0) begin bad++;
      $display("FAIL wait_sup_acc: nwait=%b want 0", cpu_nwait); end
    tick();
    total++; if (cpu_nwait !== 1'b0) begin bad++;
      $display("FAIL wait_sup_lat: nwait=%b want 0", cpu_nwait); end
    tick();
    total++; if (cpu_nwait !== 1'b0 || sup_ack !== 1'b1) begin bad++;
      $display("FAIL wait_sup_done: nwait=%b ack=%b want 0/1", cpu_nwait, sup_ack); end
    sup_req = 1'b0;
    tick();
    total++; if (cpu_nwait !== 1'b1) begin bad++;
      $display("FAIL wait_release: nwait=%b want 1", cpu_nwait); end
    tick();
    total++; if (ram_a !== 16'h4001 || ram_we !== 1'b0) begin bad++;
      $display("FAIL cpu_after_sup: a=%h we=%b want 4001/0", ram_a, ram_we); end
    tick();
    tick();
    total++; if (cpu_q !== 8'hC3) begin bad++;
      $display("FAIL cpu_after_sup_data: d=%h want c3", cpu_q); end
    cpu_idle();
    tick();
  endtask

  task automatic test_starve();
    int cpu_grants = 0;
    int sup_early  = 0;
    sup_req = 1'b1; sup_we = 1'b1; sup_a = 16'hC200; sup_d = 8'h99;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        cpu_a = 16'h5000 + 16'(i); cpu_d = 8'(i) + 8'h10; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
      end else begin
        cpu_idle();
      end
      tick();
      if (ram_we && ram_a == 16'h5000 + 16'(i)) cpu_grants++;
      if (ram_a == 16'hC200) sup_early++;
    end
    total++; if (cpu_grants != 4 || sup_early != 0) begin bad++;
      $display("FAIL starve_cpu_first: cpu=%0d sup=%0d want 4/0", cpu_grants, sup_early); end
    cpu_a = 16'h5008; cpu_d = 8'h18; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
    tick();
    total++; if (ram_a !== 16'hC200 || ram_we !== 1'b1 || ram_d !== 8'h99 || cpu_nwait !== 1'b0) begin bad++;
      $display("FAIL starve_sup_win: a=%h we=%b d=%h nwait=%b want c200/1/99/0", ram_a, ram_we, ram_d, cpu_nwait); end
    total++; if (mem[16'h5002] !== 8'h12 || mem[16'h5006] !== 8'h16) begin bad++;
      $display("FAIL starve_cpu_mem: %h %h want 12 16", mem[16'h5002], mem[16'h5006]); end
    tick();
    tick();
    total++; if (sup_ack !== 1'b1 || cpu_nwait !== 1'b0) begin bad++;
      $display("FAIL starve_ack: ack=%b nwait=%b want 1/0", sup_ack, cpu_nwait); end
    sup_req = 1'b0;
    tick();
    tick();
    total++; if (ram_a !== 16'h5008 || ram_we !== 1'b1) begin bad++;
      $display("FAIL starve_cpu_next: a=%h we=%b want 5008/1", ram_a, ram_we); end
    cpu_idle();
    tick();
  endtask

  task automatic test_served();
    cpu_a = 16'h4000; cpu_nmreq = 1'b0; cpu_nrd = 1'b0;
    tick();
    tick();
    tick();
    total++; if (cpu_q !== 8'h5A) begin bad++;
      $display("FAIL served_read: d=%h want 5a", cpu_q); end
    sup_req = 1'b1; sup_we = 1'b0; sup_a = 16'hC000;
    tick();
    total++; if (ram_a !== 16'hC000 || cpu_nwait !== 1'b1) begin bad++;
      $display("FAIL served_no_repeat: a=%h nwait=%b want c000/1", ram_a, cpu_nwait); end
    tick();
    tick();
    sup_req = 1'b0;
    tick();
    cpu_idle();
    tick();
  endtask

  task automatic test_reset_mid_access();
    int acks = 0;
    cpu_write(16'hC100, 8'h11);
    sup_req = 1'b1; sup_we = 1'b1; sup_a = 16'hC100; sup_d = 8'h77;
    tick();
    total++; if (ram_we !== 1'b1 || ram_a !== 16'hC100) begin bad++;
      $display("FAIL rst_pre: we=%b a=%h want 1/c100", ram_we, ram_a); end
    #1 rst = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0 || ram_a !== 16'h0 || ram_d !== 8'h0) begin bad++;
      $display("FAIL rst_mid_ram: we=%b a=%h d=%h want 0/0000/00", ram_we, ram_a, ram_d); end
    total++; if (cpu_q !== 8'hFF || cpu_nwait !== 1'b1 || sup_ack !== 1'b0 || sup_q !== 8'h00) begin bad++;
      $display("FAIL rst_mid_out: d=%h nwait=%b ack=%b sd=%h want ff/1/0/00", cpu_q, cpu_nwait, sup_ack, sup_q); end
    sup_req = 1'b0;
    tick();
    @(negedge clk) rst = 1'b0;
    cpu_a = 16'hC101; cpu_d = 8'h22; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
    tick();
    total++; if (ram_we !== 1'b1 || ram_a !== 16'hC101) begin bad++;
      $display("FAIL rst_first_edge: we=%b a=%h want 1/c101", ram_we, ram_a); end
    if (sup_ack) acks++;
    cpu_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sup_ack) acks++;
    end
    total++; if (acks != 0) begin bad++;
      $display("FAIL rst_no_ack: acks=%0d want 0", acks); end
    total++; if (mem[16'hC100] !== 8'h11 || mem[16'hC101] !== 8'h22) begin bad++;
      $display("FAIL rst_mem: c100=%h c101=%h want 11/22", mem[16'hC100], mem[16'hC101]); end
  endtask

  initial begin
    rst = 1'b1;
    cpu_a = '0; cpu_d = '0;
    cpu_idle();
    sup_req = 1'b0; sup_we = 1'b0; sup_a = '0; sup_d = '0;
    test_reset();
    test_cpu_write_read();
    test_sup_write_read();
    test_cpu_during_sup();
    test_starve();
    test_served();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
